touch_key_gen: RTL
==================

Name: touch_key_gen

Overview:
- Transmitter-side emulator of the capacitive touch-key signal; the receiver is the existing touch-key-to-LED toggle logic.
- Accepts press commands over a req/busy handshake and drives a single-bit touch_key line.
- Each press has a programmable hold length, optional contact bounce on press and release, and an enforced release gap.
- Used on-board for self-test of key-consuming logic and as a reusable stimulus source in benches.

Parameters:
- CNT_W, 24, width of hold_len and of the internal phase counter.
- BOUNCE_PERIOD, 50, clock cycles per bounce half-period (>=1).
- BOUNCE_NUM, 4, number of bounce high pulses per edge (>=1).
- GAP_CYCLES, 100, low cycles enforced after each press before done (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- req  in  1  press request; sampled only while busy=0.
- hold_len  in  CNT_W  stable-high cycles; latched on accept; 0 is treated as 1.
- bounce_en  in  1  enables press/release bounce; latched on accept.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse when the press sequence completes.
- touch_key  out  1  emulated sensor output, registered.
- press_cnt  out  8  completed-hold counter; wraps 255 -> 0.

Behaviour:
- Reset (async, rst=1): state IDLE; touch_key=0, busy=0, done=0, press_cnt=0; latched fields cleared. Reset during any phase aborts immediately, with no done pulse.
- States: IDLE, BOUNCE_ON, HOLD, BOUNCE_OFF, GAP.
- Accept: clock edge T with state IDLE and req=1. hold_len and bounce_en are latched; from T+1, busy=1 and touch_key is set per the next state. req while busy is ignored (not queued).
- IDLE -> BOUNCE_ON if bounce_en, else -> HOLD.
- BOUNCE_ON: touch_key high for BOUNCE_PERIOD, then low for BOUNCE_PERIOD, repeated BOUNCE_NUM times (2*BOUNCE_NUM*BOUNCE_PERIOD cycles), then -> HOLD.
- HOLD: touch_key=1 for max(hold_len,1) cycles. press_cnt increments on entry to HOLD. Next state is BOUNCE_OFF if bounce_en, else GAP.
- BOUNCE_OFF: low for BOUNCE_PERIOD, then high for BOUNCE_PERIOD, repeated BOUNCE_NUM times, then -> GAP.
- GAP: touch_key=0 for GAP_CYCLES cycles, then -> IDLE.
- Completion: on the cycle the FSM re-enters IDLE, done=1 and busy=0. A req present in that same cycle is accepted, so presses run back-to-back.
- Phase counter: one down-counter of CNT_W bits, loaded at each phase/half-period boundary. No combinational path from inputs to outputs.
- hold_len is clamped to a minimum of 1 at the latch. BOUNCE_PERIOD and GAP_CYCLES must fit in CNT_W (checked by an elaboration assertion).

Decomposition:
- Shared package touch_pkg: state enum (IDLE, BOUNCE_ON, HOLD, BOUNCE_OFF, GAP) and default constants for BOUNCE_PERIOD, BOUNCE_NUM and GAP_CYCLES.
- One sub-module, touch_phase_timer: loadable CNT_W down-counter with a load/expire interface.
- Bounce-pulse counter and FSM stay in touch_key_gen.

Test Plan (BOUNCE_PERIOD=4, BOUNCE_NUM=2, GAP_CYCLES=10, accept at cycle 0):
- No bounce, hold_len=100 -> touch_key high cycles 1..100, low from 101; done at 111; busy high 1..110; press_cnt=1.
- bounce_en=1, hold_len=20 -> touch_key:
  - 1-4 H, 5-8 L, 9-12 H, 13-16 L
  - 17-36 H
  - 37-40 L, 41-44 H, 45-48 L, 49-52 H
  - 53-62 L
  - done at 63.
- hold_len=0, no bounce -> touch_key high at cycle 1 only; done at 12.
- req held high continuously, hold_len=5 -> second accept in the done cycle (16); touch_key high 17..21; req pulses while busy produce no extra press.
- rst pulsed at cycle 50 of a hold_len=100 press -> touch_key, busy and press_cnt go 0 asynchronously; no done pulse; next req restarts cleanly.
- 256 presses with hold_len=1 -> press_cnt reads 0 after the 256th press and 255 before it.

Source files
------------

// File: rtl/touch_pkg.sv
// rtl/touch_pkg.sv - shared state encoding and default timing constants for touch_key_gen
package touch_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        BOUNCE_ON  = 3'd1,
        HOLD       = 3'd2,
        BOUNCE_OFF = 3'd3,
        GAP        = 3'd4
    } touch_state_e;

    localparam int DEF_BOUNCE_PERIOD = 50;
    localparam int DEF_BOUNCE_NUM    = 4;
    localparam int DEF_GAP_CYCLES    = 100;

endpackage

// File: rtl/touch_phase_timer.sv
// rtl/touch_phase_timer.sv - loadable down-counter; expire_o marks the last cycle of a loaded phase
module touch_phase_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A phase of length N is loaded with N, so the count reads 1 during its final cycle.
    assign expire_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/touch_key_gen.sv
// rtl/touch_key_gen.sv - touch-key press emulator: optional bounce, programmable hold, enforced release gap
module touch_key_gen
    import touch_pkg::*;
#(
    parameter int CNT_W         = 24,
    parameter int BOUNCE_PERIOD = DEF_BOUNCE_PERIOD,
    parameter int BOUNCE_NUM    = DEF_BOUNCE_NUM,
    parameter int GAP_CYCLES    = DEF_GAP_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [CNT_W-1:0] hold_len,
    input  logic             bounce_en,
    output logic             busy,
    output logic             done,
    output logic             touch_key,
    output logic [7:0]       press_cnt
);

    localparam int HALF_W = (2 * BOUNCE_NUM > 1) ? $clog2(2 * BOUNCE_NUM) : 1;
    localparam logic [HALF_W-1:0] HALVES_LAST = HALF_W'(2 * BOUNCE_NUM - 1);
    localparam logic [CNT_W-1:0]  BP_VAL      = CNT_W'(BOUNCE_PERIOD);
    localparam logic [CNT_W-1:0]  GAP_VAL     = CNT_W'(GAP_CYCLES);

    if (BOUNCE_PERIOD < 1 || BOUNCE_NUM < 1 || GAP_CYCLES < 1 ||
        (BOUNCE_PERIOD >> CNT_W) != 0 || (GAP_CYCLES >> CNT_W) != 0) begin : g_param_check
        $error("touch_key_gen: BOUNCE_PERIOD/GAP_CYCLES out of range for CNT_W");
    end

    touch_state_e      state_q;
    logic [CNT_W-1:0]  hold_q;
    logic              bounce_q;
    logic [HALF_W-1:0] halves_q;
    logic              touch_q;
    logic              busy_q;
    logic              done_q;
    logic [7:0]        press_cnt_q;

    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_last;
    logic [CNT_W-1:0]  hold_clamped;

    assign hold_clamped = (hold_len == '0) ? CNT_W'(1) : hold_len;

    // Timer reload: length of whichever phase or half-period starts on the next edge.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = BP_VAL;
        unique case (state_q)
            IDLE: begin
                tmr_load = req;
                tmr_val  = bounce_en ? BP_VAL : hold_clamped;
            end
            BOUNCE_ON: begin
                tmr_load = tmr_last;
                tmr_val  = (halves_q == '0) ? hold_q : BP_VAL;
            end
            HOLD: begin
                tmr_load = tmr_last;
                tmr_val  = bounce_q ? BP_VAL : GAP_VAL;
            end
            BOUNCE_OFF: begin
                tmr_load = tmr_last;
                tmr_val  = (halves_q == '0) ? GAP_VAL : BP_VAL;
            end
            default: begin
                tmr_load = 1'b0;
                tmr_val  = BP_VAL;
            end
        endcase
    end

    touch_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            bounce_q    <= 1'b0;
            halves_q    <= '0;
            touch_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        hold_q   <= hold_clamped;
                        bounce_q <= bounce_en;
                        halves_q <= HALVES_LAST;
                        busy_q   <= 1'b1;
                        touch_q  <= 1'b1;
                        if (bounce_en) begin
                            state_q <= BOUNCE_ON;
                        end else begin
                            state_q     <= HOLD;
                            press_cnt_q <= press_cnt_q + 8'd1;
                        end
                    end
                end
                BOUNCE_ON: begin
                    if (tmr_last) begin
                        if (halves_q == '0) begin
                            state_q     <= HOLD;
                            touch_q     <= 1'b1;
                            press_cnt_q <= press_cnt_q + 8'd1;
                        end else begin
                            touch_q  <= ~touch_q;
                            halves_q <= halves_q - HALF_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (tmr_last) begin
                        touch_q  <= 1'b0;
                        halves_q <= HALVES_LAST;
                        state_q  <= bounce_q ? BOUNCE_OFF : GAP;
                    end
                end
                BOUNCE_OFF: begin
                    if (tmr_last) begin
                        if (halves_q == '0) begin
                            state_q <= GAP;
                            touch_q <= 1'b0;
                        end else begin
                            touch_q  <= ~touch_q;
                            halves_q <= halves_q - HALF_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (tmr_last) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    touch_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign touch_key = touch_q;
    assign press_cnt = press_cnt_q;

endmodule
